// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : funct codes and MDU state encoding shared by alu_mdu and mdu_iter
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
// mdu_iter : one-bit-per-cycle unsigned shift-add multiplier / restoring divider
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  // acc holds the product high half / partial remainder; quo holds the
  // multiplier being consumed / the dividend being replaced by quotient bits
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q, quo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    acc_d = acc_q;
    quo_d = quo_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    if (load) begin
      acc_d = '0;
      quo_d = op_a;
      opb_d = op_b;
      cnt_d = CNT_W'(WIDTH);
    end else if (step) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (is_div) begin
        // a zero divisor never borrows: quotient all ones, remainder = dividend
        if (!div_diff[WIDTH]) begin
          acc_d = div_diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        {acc_d, quo_d} = {mul_sum, quo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      quo_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      quo_q <= quo_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
    end
  end

  assign last   = (cnt_q == CNT_W'(1));
  assign res_hi = acc_d;
  assign res_lo = quo_d;

endmodule

`default_nettype wire

// File: rtl/alu_mdu.sv
// ============================================================================
// alu_mdu : EX-stage ALU with registered result and iterative MUL/DIV (HI/LO)
// Optional: define ALU_MDU_SIGNED_EN to add signed MULT / DIV
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             out_valid,
  output logic [WIDTH-1:0] dataOut,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  mdu_state_t       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf, alu_ill;
  logic             op_mul, op_div, accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] it_hi, it_lo, fin_hi, fin_lo;
  logic             it_last, mdu_load, mdu_step, mdu_is_div;

`ifdef ALU_MDU_SIGNED_EN
  logic             op_signed;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
`endif

  assign in_ready = (state_q == IDLE) && reset;
  assign accept   = in_valid && in_ready;
  assign sum      = dataA + dataB;
  assign diff     = dataA - dataB;

  always_comb begin
    op_mul = (Signal == FN_MULTU);
    op_div = (Signal == FN_DIVU);
    mag_a  = dataA;
    mag_b  = dataB;
`ifdef ALU_MDU_SIGNED_EN
    op_signed = (Signal == FN_MULT) || (Signal == FN_DIV);
    op_mul    = op_mul || (Signal == FN_MULT);
    op_div    = op_div || (Signal == FN_DIV);
    if (op_signed) begin
      mag_a = dataA[WIDTH-1] ? -dataA : dataA;
      mag_b = dataB[WIDTH-1] ? -dataB : dataB;
    end
`endif
  end

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (Signal)
      FN_ADD: begin
        alu_res = sum;
        alu_ovf = (dataA[WIDTH-1] == dataB[WIDTH-1]) && (sum[WIDTH-1] != dataA[WIDTH-1]);
      end
      FN_SUB: begin
        alu_res = diff;
        alu_ovf = (dataA[WIDTH-1] != dataB[WIDTH-1]) && (diff[WIDTH-1] != dataA[WIDTH-1]);
      end
      FN_AND:  alu_res = dataA & dataB;
      FN_OR:   alu_res = dataA | dataB;
      FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      FN_SRL:  alu_res = dataA >> dataB[CNT_W-2:0];
      FN_MFHI: alu_res = hi_q;
      FN_MFLO: alu_res = lo_q;
      default: alu_ill = 1'b1;
    endcase
  end

  // The iterator works on magnitudes; signs are re-applied as HI/LO are written
  always_comb begin
    fin_hi = it_hi;
    fin_lo = it_lo;
`ifdef ALU_MDU_SIGNED_EN
    if (state_q == MUL && neg_q_q) begin
      {fin_hi, fin_lo} = -{it_hi, it_lo};
    end
    if (state_q == DIV) begin
      if (neg_q_q) fin_lo = -it_lo;
      if (neg_r_q) fin_hi = -it_hi;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;
    zero_d      = zero_q;
    mdu_load    = 1'b0;
`ifdef ALU_MDU_SIGNED_EN
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_mul || op_div) begin
            state_d  = op_div ? DIV : MUL;
            mdu_load = 1'b1;
`ifdef ALU_MDU_SIGNED_EN
            neg_q_d  = op_signed && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
            neg_r_d  = op_signed && dataA[WIDTH-1];
`endif
          end else begin
            out_valid_d = 1'b1;
            data_out_d  = alu_res;
            overflow_d  = alu_ovf;
            illegal_d   = alu_ill;
            zero_d      = (alu_res == '0);
          end
        end
      end
      MUL, DIV: begin
        if (it_last) begin
          state_d     = DONE;
          hi_d        = fin_hi;
          lo_d        = fin_lo;
          data_out_d  = fin_lo;
          out_valid_d = 1'b1;
          overflow_d  = 1'b0;
          illegal_d   = 1'b0;
          zero_d      = (fin_lo == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      zero_q      <= 1'b0;
`ifdef ALU_MDU_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
      zero_q      <= zero_d;
`ifdef ALU_MDU_SIGNED_EN
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
`endif
    end
  end

  assign mdu_step   = (state_q == MUL) || (state_q == DIV);
  assign mdu_is_div = (state_q == DIV);

  mdu_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (mdu_load),
    .step   (mdu_step),
    .is_div (mdu_is_div),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .last   (it_last),
    .res_hi (it_hi),
    .res_lo (it_lo)
  );

  assign out_valid = out_valid_q;
  assign dataOut   = data_out_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;
  assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu.sv
// ============================================================================
// tb_alu_mdu : directed self-checking bench for alu_mdu (WIDTH = 32)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_mdu;

  localparam int W = 32;

  localparam logic [5:0] C_ADD   = 6'b100000;
  localparam logic [5:0] C_SUB   = 6'b100010;
  localparam logic [5:0] C_AND   = 6'b100100;
  localparam logic [5:0] C_OR    = 6'b100101;
  localparam logic [5:0] C_SLT   = 6'b101010;
  localparam logic [5:0] C_SRL   = 6'b000010;
  localparam logic [5:0] C_MFHI  = 6'b010000;
  localparam logic [5:0] C_MFLO  = 6'b010010;
  localparam logic [5:0] C_MULTU = 6'b011001;
  localparam logic [5:0] C_DIVU  = 6'b011011;
  localparam logic [5:0] C_MULT  = 6'b011000;
  localparam logic [5:0] C_DIV   = 6'b011010;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   Signal;
  logic [W-1:0] dataA, dataB;
  logic         out_valid;
  logic [W-1:0] dataOut;
  logic         overflow, zero, illegal;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Signal    (Signal),
    .dataA     (dataA),
    .dataB     (dataB),
    .out_valid (out_valid),
    .dataOut   (dataOut),
    .overflow  (overflow),
    .zero      (zero),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single-cycle op: result must be visible right after the accepting edge
  task automatic op1(input string tag, input logic [5:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp,
                     input logic eovf, input logic eill);
    Signal = op; dataA = a; dataB = b; in_valid = 1'b1;
    check({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_res"}, dataOut, exp);
    check({tag, "_ovf"}, overflow, eovf);
    check({tag, "_ill"}, illegal, eill);
    check({tag, "_zero"}, zero, (exp == '0));
  endtask

  // Iterative op: a stray request is held while busy and must be ignored
  task automatic mdu_op(input string tag, input logic [5:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_lo);
    int cyc;
    int low_rdy;
    Signal = op; dataA = a; dataB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    Signal = C_ADD;
    cyc = 1;
    low_rdy = 0;
    while (!out_valid && cyc < 3*W) begin
      if (!in_ready) low_rdy++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, cyc, W + 1);
    check({tag, "_busy"}, low_rdy, W);
    check({tag, "_lo"}, dataOut, exp_lo);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_ill"}, illegal, 0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, out_valid, 0);
    check({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    reset = 1'b0; in_valid = 1'b1; Signal = C_ADD; dataA = 1; dataB = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_vld", out_valid, 0);
      check("rst_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rel_rdy", in_ready, 1);
    check("rel_out", {out_valid, dataOut, overflow, zero, illegal}, 0);
    @(posedge clk); #1;

    op1("add_ovf", C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 0);
    op1("sub_zero", C_SUB, 32'd5, 32'd5, 32'd0, 0, 0);
    op1("add_wrap", C_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, 0);
    op1("sub_ovf", C_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 0);
    op1("and", C_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0, 0);
    op1("or", C_OR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 0, 0);
    op1("slt_t", C_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 0);
    op1("slt_f", C_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0);
    op1("srl_mask", C_SRL, 32'hF000_0000, 32'h0000_0024, 32'h0F00_0000, 0, 0);
    op1("srl_31", C_SRL, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);

    mdu_op("multu", C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    op1("mfhi_mul", C_MFHI, 0, 0, 32'hFFFF_FFFE, 0, 0);
    op1("mflo_mul", C_MFLO, 0, 0, 32'h0000_0001, 0, 0);
    mdu_op("divu", C_DIVU, 32'd100, 32'd7, 32'd14);
    op1("mfhi_div", C_MFHI, 0, 0, 32'd2, 0, 0);
    mdu_op("divu0", C_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF);
    op1("mfhi_div0", C_MFHI, 0, 0, 32'd9, 0, 0);

    op1("illegal", 6'b111111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 0, 1);
    op1("ill_hi", C_MFHI, 0, 0, 32'd9, 0, 0);
    op1("ill_lo", C_MFLO, 0, 0, 32'hFFFF_FFFF, 0, 0);

`ifdef ALU_MDU_SIGNED_EN
    mdu_op("mult", C_MULT, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4);
    op1("mult_hi", C_MFHI, 0, 0, 32'hFFFF_FFFF, 0, 0);
    mdu_op("div", C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    op1("div_hi", C_MFHI, 0, 0, 32'hFFFF_FFFF, 0, 0);
    mdu_op("div_mn", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    op1("div_mn_hi", C_MFHI, 0, 0, 32'd0, 0, 0);
`else
    op1("mult_ill", C_MULT, 32'd3, 32'd4, 32'd0, 0, 1);
    op1("div_ill", C_DIV, 32'd7, 32'd2, 32'd0, 0, 1);
`endif

    // Abandon a MULTU mid-iteration
    Signal = C_MULTU; dataA = 32'h0001_0001; dataB = 32'h0000_0003; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_rdy", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("mid_rst_pulses", pulses, 0);
    op1("mid_rst_hi", C_MFHI, 0, 0, 32'd0, 0, 0);
    op1("mid_rst_lo", C_MFLO, 0, 0, 32'd0, 0, 0);
    op1("after_rst_add", C_ADD, 32'd1, 32'd1, 32'd2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
